// File: rtl/button_conditioner.sv
// button_conditioner
//   Synchronises, debounces and edge-detects the four wing push buttons and
//   generates the stretched system reset for the downstream SoC.
//
// Ports
//   clk          board clock, all logic on its rising edge
//   reset        synchronous active-high power-on/external reset
//   buttons_raw  asynchronous raw button levels, 1 = pressed
//   btn_level    debounced level per button
//   btn_press    one-cycle strobe on a debounced 0->1 transition
//   btn_release  one-cycle strobe on a debounced 1->0 transition
//   rst_out      active-high synchronous system reset for downstream logic
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 320000,
  parameter int unsigned RESET_CYCLES    = 16,
  parameter int unsigned RESET_BTN       = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] buttons_raw,
  output logic [3:0] btn_level,
  output logic [3:0] btn_press,
  output logic [3:0] btn_release,
  output logic       rst_out
);

  // A single-cycle debounce still needs a 1-bit counter so the width never collapses to 0.
  localparam int unsigned CntW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned RcntW = $clog2(RESET_CYCLES + 1);

  localparam logic [CntW-1:0]  CntMax   = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RcntW-1:0] RcntLoad = RcntW'(RESET_CYCLES);
  localparam logic [1:0]       RstIdx   = 2'(RESET_BTN);

  logic [3:0]           sync1_q, sync2_q;
  logic [3:0][CntW-1:0] cnt_q, cnt_d;
  logic [3:0]           level_d, press_d, release_d;
  logic [RcntW-1:0]     rcnt_q, rcnt_d;
  logic                 rst_out_d;

  // Debounce lanes: a level is accepted only after DEBOUNCE_CYCLES consecutive
  // mismatching samples; any matching sample restarts the count.
  always_comb begin
    level_d   = btn_level;
    press_d   = '0;
    release_d = '0;
    cnt_d     = '0;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] != btn_level[i]) begin
        if (cnt_q[i] == CntMax) begin
          level_d[i]   = sync2_q[i];
          press_d[i]   = sync2_q[i];
          release_d[i] = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Reset stretcher. The external reset term is covered by the synchronous
  // reset branch below, which loads the same values.
  always_comb begin
    if (btn_level[RstIdx]) begin
      rcnt_d    = RcntLoad;
      rst_out_d = 1'b1;
    end else if (rcnt_q != '0) begin
      rcnt_d    = rcnt_q - 1'b1;
      rst_out_d = 1'b1;
    end else begin
      rcnt_d    = rcnt_q;
      rst_out_d = 1'b0;
    end
  end

  // rst_out is deliberately not fed back: only the external reset clears this block.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      cnt_q       <= '0;
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      rcnt_q      <= RcntLoad;
      rst_out     <= 1'b1;
    end else begin
      sync1_q     <= buttons_raw;
      sync2_q     <= sync1_q;
      cnt_q       <= cnt_d;
      btn_level   <= level_d;
      btn_press   <= press_d;
      btn_release <= release_d;
      rcnt_q      <= rcnt_d;
      rst_out     <= rst_out_d;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

  localparam int unsigned Deb = 8;
  localparam int unsigned Rst = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] buttons_raw;
  logic [3:0] btn_level, btn_press, btn_release;
  logic       rst_out;

  int n_cmp  = 0;
  int n_fail = 0;

  button_conditioner #(
    .DEBOUNCE_CYCLES(Deb),
    .RESET_CYCLES   (Rst),
    .RESET_BTN      (0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .buttons_raw(buttons_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .rst_out    (rst_out)
  );

  always #5 clk = ~clk;

  // Reference model: raw samples reach the debouncer two edges late; a level is
  // accepted on the Deb-th consecutive disagreeing edge; rst_out is high while
  // fewer than Rst+1 edges have passed since the last edge with a reset cause.
  logic [3:0] m_hist1, m_hist2;
  logic [3:0] m_level, m_press, m_rel;
  int         m_run[4];
  int         m_since;

  function automatic void model_step(input logic r, input logic [3:0] b);
    logic [3:0] s;
    logic       cause;
    if (r) begin
      m_hist1 = '0;
      m_hist2 = '0;
      m_level = '0;
      m_press = '0;
      m_rel   = '0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      m_since = 0;
    end else begin
      s       = m_hist2;
      cause   = m_level[0];
      m_hist2 = m_hist1;
      m_hist1 = b;
      m_press = '0;
      m_rel   = '0;
      for (int i = 0; i < 4; i++) begin
        if (s[i] != m_level[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == int'(Deb)) begin
            m_level[i] = s[i];
            m_press[i] = s[i];
            m_rel[i]   = ~s[i];
            m_run[i]   = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      if (cause) m_since = 0;
      else if (m_since <= int'(Rst)) m_since = m_since + 1;
    end
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got %h expected %h", name, $time, got, exp);
    end
  endtask

  function automatic logic [15:0] dut_word();
    return {3'b0, btn_level, btn_press, btn_release, rst_out};
  endfunction

  // One clock edge: model advances with the inputs present at the edge, then
  // all outputs are compared against it.
  task automatic tick();
    logic       r;
    logic [3:0] b;
    logic       exp_rst;
    r = reset;
    b = buttons_raw;
    @(posedge clk);
    #1;
    model_step(r, b);
    exp_rst = (m_since <= int'(Rst));
    check("model", dut_word(), {3'b0, m_level, m_press, m_rel, exp_rst});
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] raw;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rel;
    logic       ro;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic r, input logic [3:0] raw, input logic [3:0] lvl,
                         input logic [3:0] prs, input logic [3:0] rel, input logic ro);
    vec_t v;
    v.rst = r; v.raw = raw; v.lvl = lvl; v.prs = prs; v.rel = rel; v.ro = ro;
    vecs.push_back(v);
  endtask

  initial begin
    logic       bad;
    int         rise_idx, fall_idx, n_prs, n_rel;
    logic       lv0[45];
    logic       ro[45];
    logic [3:0] raw_r;
    int         hold[4];
    int         rhold;

    reset       = 1'b1;
    buttons_raw = '0;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
    m_hist1 = '0; m_hist2 = '0; m_level = '0; m_press = '0; m_rel = '0; m_since = 0;

    // Power-on reset, then a clean press of button 2 (sampling edge is entry 8).
    for (int i = 0; i < 3; i++) add_vec(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
    for (int i = 0; i < 4; i++) add_vec(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
    add_vec(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    for (int i = 0; i < 9; i++) add_vec(1'b0, 4'h4, 4'h0, 4'h0, 4'h0, 1'b0);
    add_vec(1'b0, 4'h4, 4'h4, 4'h4, 4'h0, 1'b0);
    for (int i = 0; i < 10; i++) add_vec(1'b0, 4'h4, 4'h4, 4'h0, 4'h0, 1'b0);

    foreach (vecs[k]) begin
      reset       = vecs[k].rst;
      buttons_raw = vecs[k].raw;
      tick();
      check("vec", dut_word(),
            {3'b0, vecs[k].lvl, vecs[k].prs, vecs[k].rel, vecs[k].ro});
    end

    // Bounce on button 1 while button 2 stays held.
    bad = 1'b0;
    for (int k = 0; k < 26; k++) begin
      buttons_raw = {2'b01, (k < 5 || (k >= 6 && k < 11)), 1'b0};
      tick();
      if (btn_level[1] || btn_press[1] || btn_release[1]) bad = 1'b1;
    end
    check("bounce_no_change", {15'b0, bad}, 16'h0);

    // Release button 2: strobe on the 10th edge counting the sampling edge.
    buttons_raw = 4'h0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 9)  check("release_early", {8'b0, btn_release, btn_level}, {8'b0, 4'h0, 4'h4});
      if (k == 10) check("release_strobe", {8'b0, btn_release, btn_level}, {8'b0, 4'h4, 4'h0});
      if (k == 11) check("release_width", {12'b0, btn_release}, 16'h0);
    end

    // Reset button held 15 cycles.
    n_prs = 0; n_rel = 0;
    for (int k = 0; k < 45; k++) begin
      buttons_raw = (k < 15) ? 4'h1 : 4'h0;
      tick();
      lv0[k] = btn_level[0];
      ro[k]  = rst_out;
      if (btn_press[0])   n_prs++;
      if (btn_release[0]) n_rel++;
    end
    rise_idx = -1; fall_idx = -1;
    for (int k = 0; k < 45; k++) begin
      if (rise_idx < 0 && lv0[k]) rise_idx = k;
      if (rise_idx >= 0 && fall_idx < 0 && !lv0[k]) fall_idx = k;
    end
    check("rstbtn_rise_idx", 16'(rise_idx), 16'd9);
    check("rstbtn_fall_idx", 16'(fall_idx), 16'd24);
    check("rstbtn_press_cnt", 16'(n_prs), 16'd1);
    check("rstbtn_release_cnt", 16'(n_rel), 16'd1);
    bad = 1'b0;
    for (int k = 10; k <= 28; k++) if (!ro[k]) bad = 1'b1;
    check("rstbtn_held_high", {15'b0, bad}, 16'h0);
    check("rstbtn_fall", {15'b0, ro[29]}, 16'h0);

    // Reset mid-debounce on button 3: count reaches 5 after the 7th edge.
    bad = 1'b0;
    buttons_raw = 4'h8;
    for (int k = 0; k < 7; k++) begin
      tick();
      if (btn_press != 4'h0 || btn_release != 4'h0) bad = 1'b1;
    end
    check("middeb_no_early", {15'b0, bad}, 16'h0);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("middeb_in_reset", dut_word(), 16'h0001);
    end
    reset = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 4)  check("middeb_rst_hold", {15'b0, rst_out}, 16'h1);
      if (k == 5)  check("middeb_rst_fall", {15'b0, rst_out}, 16'h0);
      if (k == 9)  check("middeb_press_early", {12'b0, btn_press}, 16'h0);
      if (k == 10) check("middeb_press", {12'b0, btn_press}, 16'h8);
      if (k == 11) check("middeb_press_width", {12'b0, btn_press}, 16'h0);
    end
    buttons_raw = 4'h0;
    for (int k = 0; k < 15; k++) tick();

    // Random traffic: per-lane hold times straddle the debounce window, with
    // occasional reset bursts.
    raw_r = '0;
    rhold = 0;
    for (int i = 0; i < 4; i++) hold[i] = int'($urandom_range(1, 14));
    for (int c = 0; c < 4000; c++) begin
      if (rhold == 0 && $urandom_range(0, 299) == 0) rhold = int'($urandom_range(1, 3));
      if (rhold > 0) begin
        reset = 1'b1;
        rhold--;
      end else begin
        reset = 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
        if (hold[i] == 0) begin
          raw_r[i] = ~raw_r[i];
          hold[i]  = int'($urandom_range(1, 14));
        end else begin
          hold[i]--;
        end
      end
      buttons_raw = raw_r;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
